// File: rtl/ea_sequencer.sv
// LC-3 effective-address sequencer: decode, one shared 16-bit adder, and an
// optional indirect pointer fetch over a req/ack handshake with timeout.
module ea_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic [15:0] PC,
  input  logic [15:0] BaseR,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ready,
  output logic [2:0]  sr1_sel,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        done,
  output logic [15:0] EA,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ADD, S_IND, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]      ir_q, pc_q, off_q, ea_q;
  logic             base_sel_q, ind_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  // decode results, registered at the end of DECODE
  logic [15:0] dec_off;
  logic        dec_base, dec_ind, dec_ill;
  logic        last_wait;

  assign last_wait = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    dec_off  = '0;
    dec_base = 1'b0;
    dec_ind  = 1'b0;
    dec_ill  = 1'b0;
    case (ir_q[15:12])
      4'b0000, 4'b0010, 4'b0011, 4'b1110:
        dec_off = {{7{ir_q[8]}}, ir_q[8:0]};
      4'b1010, 4'b1011: begin
        dec_off = {{7{ir_q[8]}}, ir_q[8:0]};
        dec_ind = 1'b1;
      end
      4'b0100: begin
        if (ir_q[11]) dec_off = {{5{ir_q[10]}}, ir_q[10:0]};
        else          dec_base = 1'b1;
      end
      4'b1100: dec_base = 1'b1;
      4'b0110, 4'b0111: begin
        dec_base = 1'b1;
        dec_off  = {{10{ir_q[5]}}, ir_q[5:0]};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_DECODE;
      S_DECODE: state_nx = dec_ill ? S_DONE : S_ADD;
      S_ADD:    state_nx = ind_q ? S_IND : S_DONE;
      // ack on the final wait cycle wins over the timeout
      S_IND:    if (mem_ack || last_wait) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_q       <= '0;
      pc_q       <= '0;
      off_q      <= '0;
      ea_q       <= '0;
      base_sel_q <= 1'b0;
      ind_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ir_q  <= IR;
          pc_q  <= PC;
          err_q <= 1'b0;
          cnt_q <= '0;
        end
        S_DECODE: begin
          off_q      <= dec_off;
          base_sel_q <= dec_base;
          ind_q      <= dec_ind;
          if (dec_ill) begin
            err_q <= 1'b1;
            ea_q  <= '0;
          end
        end
        S_ADD: begin
          ea_q  <= (base_sel_q ? BaseR : pc_q) + off_q;
          cnt_q <= '0;
        end
        S_IND: begin
          if (mem_ack) ea_q <= mem_rdata;
          else begin
            cnt_q <= cnt_q + 1'b1;
            if (last_wait) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign mem_req  = (state == S_IND);
  assign mem_addr = mem_req ? ea_q : '0;
  assign sr1_sel  = ir_q[8:6];
  assign EA       = ea_q;
  assign err      = err_q;

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
Multi-cycle controller that computes LC-3 effective addresses for control-flow and memory instructions. It sequences operand selection, 11/9/6-bit sign extension and a single shared 16-bit adder. For LDI/STI it runs the second memory read through a req/ack handshake. It sits between the instruction register/PC and the memory interface; the FSM issues one `start` per instruction and consumes `EA`.

Parameters:
TIMEOUT, 15, max cycles `mem_req` may stay high without `mem_ack` before the access aborts with `err`.
CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clk  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-high; clears all state immediately.
start  in  1  request to process `IR`/`PC`; accepted only when `ready`=1.
IR  in  16  instruction word; sampled on accept.
PC  in  16  incremented PC; sampled on accept.
BaseR  in  16  register-file read data for register `sr1_sel`; combinational read.
mem_ack  in  1  memory has valid `mem_rdata` this cycle.
mem_rdata  in  16  indirect pointer data.
ready  out  1  high in IDLE only.
sr1_sel  out  3  base register index, = captured IR[8:6].
mem_req  out  1  indirect read request.
mem_addr  out  16  indirect read address.
done  out  1  one-cycle pulse; `EA`/`err` valid.
EA  out  16  effective address result, held until the next accept.
err  out  1  illegal opcode or timeout; held with `EA`.

Behaviour:
- Reset values: `ready`=1, `done`=0, `mem_req`=0, `mem_addr`=0, `EA`=0, `err`=0, `sr1_sel`=0, state IDLE, counter 0.
- States: IDLE, DECODE, ADD, IND, DONE.
- IDLE:
  - `start`=1 captures `IR`/`PC`, clears `err`, then goes to DECODE.
  - `start` outside IDLE is ignored; no queuing.
- DECODE: selects base and offset from captured IR[15:12].
  - BR 0000, LD 0010, ST 0011, LEA 1110, LDI 1010, STI 1011: `PC` + SEXT9(IR[8:0]).
  - JSR 0100 with IR[11]=1: `PC` + SEXT11(IR[10:0]).
  - JSRR 0100 with IR[11]=0: `BaseR` + 0.
  - JMP/RET 1100: `BaseR` + 0.
  - LDR 0110, STR 0111: `BaseR` + SEXT6(IR[5:0]).
  - Any other opcode: `err`<=1, `EA`<=0, go to DONE (no ADD).
- ADD: `EA` <= base + offset, modulo 2^16 (carry discarded). `BaseR` is sampled this cycle; `sr1_sel` is stable from DECODE onward. LDI/STI go to IND; all others go to DONE.
- IND:
  - `mem_req`=1 and `mem_addr`=`EA` throughout.
  - On `mem_ack`: `EA` <= `mem_rdata`, drop `mem_req` next cycle, go to DONE.
  - The counter increments each IND cycle without `mem_ack`. When it reaches TIMEOUT: `err`<=1, `EA` unchanged (pointer address), go to DONE.
  - `mem_ack` on the same cycle the counter hits TIMEOUT counts as success.
  - `mem_ack` outside IND is ignored.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Latency (accept edge = cycle 0):
  - Direct: `done` in cycle 3.
  - Illegal: `done` in cycle 2.
  - Indirect: `done` in cycle 4 + number of wait cycles; `mem_req` first high in cycle 3.
- Reset mid-operation (including IND with `mem_req` high) returns to IDLE with reset values; no `done` pulse.

Test Plan:
- LDR: IR=0x62BF, BaseR=0x3000 -> `sr1_sel`=2; `EA`=0x2FFF, `err`=0, `done` in cycle 3; `ready` low in cycles 1-3.
- LEA: IR=0xE100, PC=0x3001 -> SEXT9 yields 0xFF00; `EA`=0x2F01 at cycle 3. JSR: IR=0x4FFF, PC=0xFFFF -> `EA`=0xFFFE (wrap-around).
- LDI: IR=0xA002, PC=0x3000 -> `mem_req` high from cycle 3 with `mem_addr`=0x3002; `mem_ack` in cycle 5 with `mem_rdata`=0x4000 -> `EA`=0x4000, `done` cycle 6. Repeat with `mem_ack` in cycle 3 -> `done` cycle 4.
- STI: IR=0xB0FF with `mem_ack` held low -> `mem_req` high exactly 15 cycles; then `err`=1, `EA`=PC+0x00FF, one `done` pulse; `mem_req` low afterwards.
- Illegal: IR=0x1042 (ADD) -> `done` cycle 2, `err`=1, `EA`=0. A second `start` asserted during cycles 1-2 is ignored.
- Reset asserted asynchronously mid-IND -> `mem_req`, `done`, `EA` go to 0 immediately and `ready`=1. The next `start` with IR=0xC1C0 (JMP R7), BaseR=0x1234 -> `EA`=0x1234.
